// File: rtl/prog_step_counter_if.sv
// Control and status bundle for prog_step_counter.
// The master drives the controls and the slave (the counter) returns its status.
interface prog_step_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             load;
    logic             count_en;
    logic [1:0]       c;
    logic             sat;
    logic [WIDTH-1:0] data_in;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             at_max;
    logic             at_zero;
    logic             ovf_sticky;

    modport master (
        output load, count_en, c, sat, data_in, clr_ovf,
        input  count, wrap, at_max, at_zero, ovf_sticky
    );

    modport slave (
        input  load, count_en, c, sat, data_in, clr_ovf,
        output count, wrap, at_max, at_zero, ovf_sticky
    );
endinterface

// File: rtl/prog_step_counter.sv
// Programmable up/down counter over the range 0..MAX_VAL, with wrap or saturate behaviour.
// It raises a one-cycle wrap/clip pulse and holds a sticky overflow flag.
module prog_step_counter #(
    parameter int                WIDTH   = 4,
    parameter int unsigned       STEP    = 3,
    parameter longint unsigned   MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    prog_step_counter_if.slave   bus
);
    typedef logic [WIDTH:0] ext_t;
    typedef enum logic [1:0] {
        MODE_STEP = 2'b00,
        MODE_INC  = 2'b01,
        MODE_DEC  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam ext_t             MAX_E  = ext_t'(MAX_VAL);
    localparam ext_t             STEP_E = ext_t'(STEP);
    localparam logic [WIDTH-1:0] MAX_W  = MAX_E[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_nxt;
    logic             wrap_q, wrap_nxt;
    logic             ovf_q;
    ext_t             incr, sum, wrapped;
    mode_e            mode;

    assign mode = mode_e'(bus.c);

    // The sum is one bit wider than count, so the carry survives the range check.
    always_comb begin
        count_nxt = count_q;
        wrap_nxt  = 1'b0;
        incr      = (mode == MODE_STEP) ? STEP_E : ext_t'(1);
        sum       = {1'b0, count_q} + incr;
        wrapped   = sum - (MAX_E + ext_t'(1));
        if (bus.load) begin
            count_nxt = ({1'b0, bus.data_in} > MAX_E) ? MAX_W : bus.data_in;
        end else if (bus.count_en) begin
            case (mode)
                MODE_STEP, MODE_INC: begin
                    if (sum > MAX_E) begin
                        wrap_nxt  = 1'b1;
                        count_nxt = bus.sat ? MAX_W : wrapped[WIDTH-1:0];
                    end else begin
                        count_nxt = sum[WIDTH-1:0];
                    end
                end
                MODE_DEC: begin
                    if (count_q == '0) begin
                        wrap_nxt  = 1'b1;
                        count_nxt = bus.sat ? '0 : MAX_W;
                    end else begin
                        count_nxt = count_q - 1'b1;
                    end
                end
                default: count_nxt = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            wrap_q  <= wrap_nxt;
            if (wrap_nxt)
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign bus.count      = count_q;
    assign bus.wrap       = wrap_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.at_max     = (count_q == MAX_W);
    assign bus.at_zero    = (count_q == '0);
endmodule
